uart_axis: RTL and testbench



---
 rtl/uart_axis_pkg.sv | 15 +
 rtl/uart_axis_rx.sv | 89 ++++++++
 rtl/uart_axis_tx.sv | 65 ++++++
 rtl/uart_axis.sv | 47 ++++
 tb/tb_uart_axis.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_axis_pkg.sv
// uart_axis_pkg: shared widths, oversample factor, FSM encodings and bit-timing helper for the UART
package uart_axis_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W     = 16;
    localparam int OVERSAMPLE     = 8;
    localparam int CNT_W          = PRESCALE_W + 3;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    // Clock count for prescale*mult; prescale 0 behaves as 1.
    function automatic logic [CNT_W-1:0] ticks(input logic [PRESCALE_W-1:0] p, input int mult);
        logic [PRESCALE_W-1:0] q;
        q = (p == '0) ? PRESCALE_W'(1) : p;
        return CNT_W'(q) * CNT_W'(mult);
    endfunction
endpackage

// File: rtl/uart_axis_rx.sv
// uart_axis_rx: 8N1 receiver presenting bytes on an AXI-Stream master port
// Ports: clk/rst_n; rxd synchronised serial in; m_axis_* byte output;
//        rx_busy inside a frame; rx_overrun_error/rx_frame_error one-clock pulses; prescale as TX.
module uart_axis_rx
    import uart_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [PRESCALE_W-1:0] prescale
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RX_IDLE;
            cnt              <= '0;
            idx              <= '0;
            shreg            <= '0;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            rx_busy          <= 1'b0;
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
        end else begin
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rxd) begin
                        cnt   <= ticks(prescale, OVERSAMPLE / 2) - 1'b1;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit later the start bit must still be low, otherwise it was a glitch.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxd) begin
                        state <= RX_IDLE;
                    end else begin
                        cnt     <= ticks(prescale, OVERSAMPLE) - 1'b1;
                        idx     <= '0;
                        rx_busy <= 1'b1;
                        state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {rxd, shreg[DATA_WIDTH-1:1]};
                        cnt   <= ticks(prescale, OVERSAMPLE) - 1'b1;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_W'(DATA_WIDTH - 1)) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // A byte accepted in this same cycle is not an overrun.
                        if (rxd) begin
                            m_axis_tdata     <= shreg;
                            m_axis_tvalid    <= 1'b1;
                            rx_overrun_error <= m_axis_tvalid && !m_axis_tready;
                        end else begin
                            rx_frame_error <= 1'b1;
                        end
                        rx_busy <= 1'b0;
                        state   <= RX_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_axis_tx.sv
// uart_axis_tx: 8N1 transmitter taking bytes from an AXI-Stream slave port
// Ports: clk/rst_n; s_axis_* byte input; prescale sets bit time = prescale*8 clocks;
//        txd serial out (idle high); tx_busy high while a frame is being shifted.
module uart_axis_tx
    import uart_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  tx_busy,
    input  logic [PRESCALE_W-1:0] prescale
);
    localparam int IDX_W = $clog2(DATA_WIDTH + 2);
    tx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH:0]   shreg;
    // shreg holds the data bits followed by the stop bit; the start bit is driven on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= TX_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            txd           <= 1'b1;
            s_axis_tready <= 1'b0;
            tx_busy       <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    s_axis_tready <= 1'b1;
                    txd           <= 1'b1;
                    if (s_axis_tvalid && s_axis_tready) begin
                        shreg         <= {1'b1, s_axis_tdata};
                        txd           <= 1'b0;
                        cnt           <= ticks(prescale, OVERSAMPLE) - 1'b1;
                        idx           <= '0;
                        s_axis_tready <= 1'b0;
                        tx_busy       <= 1'b1;
                        state         <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx == IDX_W'(DATA_WIDTH + 1)) begin
                        s_axis_tready <= 1'b1;
                        tx_busy       <= 1'b0;
                        state         <= TX_IDLE;
                    end else begin
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[DATA_WIDTH:1]};
                        idx   <= idx + 1'b1;
                        cnt   <= ticks(prescale, OVERSAMPLE) - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_axis.sv
// uart_axis: full-duplex 8N1 UART with AXI-Stream byte ports and run-time baud prescaler
// Ports: clk/rst_n; s_axis_* bytes to send; m_axis_* received bytes; rxd/txd serial pins;
//        tx_busy/rx_busy activity; rx_overrun_error/rx_frame_error pulses; prescale (bit = prescale*8 clks).
module uart_axis
    import uart_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [PRESCALE_W-1:0] prescale
);
    uart_axis_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .prescale      (prescale)
    );
    uart_axis_rx #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
        .clk              (clk),
        .rst_n            (rst_n),
        .rxd              (rxd),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );
endmodule

// File: tb/tb_uart_axis.sv
// tb_uart_axis: directed stimulus with a byte scoreboard for uart_axis
module tb_uart_axis;
    localparam int BIT = 240;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        rxd, txd, tx_busy, rx_busy, rx_overrun_error, rx_frame_error;
    logic [15:0] prescale = 16'd30;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;
    logic [7:0]  exp_q[$];
    int          checks = 0, errors = 0;
    int          fe_cnt = 0, ov_cnt = 0, out_cnt = 0;
    logic        fe_prev = 1'b0, ov_prev = 1'b0;

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rx_drv;

    uart_axis dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output byte is popped from the scoreboard; error pulses are tallied.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no byte", m_axis_tdata);
                end else begin
                    chk("rx_byte", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
                end
            end
            if ((rx_frame_error && fe_prev) || (rx_overrun_error && ov_prev)) begin
                checks++;
                errors++;
                $display("FAIL err_pulse_width: got pulse longer than 1 clk expected 1 clk");
            end
            if (rx_frame_error) fe_cnt++;
            if (rx_overrun_error) ov_cnt++;
            fe_prev = rx_frame_error;
            ov_prev = rx_overrun_error;
        end
    end

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_drv = stop;
        repeat (BIT) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic tx_send(input logic [7:0] b);
        int n;
        n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept_in_time", {31'd0, n < 5000}, 32'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic set_tready(input logic v);
        @(posedge clk);
        #1 m_axis_tready = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        int bad;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_mdata", {24'd0, m_axis_tdata}, 32'd0);
        chk("rst_status", {28'd0, tx_busy, rx_busy, rx_overrun_error, rx_frame_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

        // TX frame timing for 0xA5
        fr = {1'b1, 8'hA5, 1'b0};
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            repeat (BIT) begin
                if (txd !== fr[b] || tx_busy !== 1'b1 || s_axis_tready !== 1'b0) bad++;
                @(negedge clk);
            end
            chk($sformatf("tx_bit%0d_bad_clks", b), bad, 0);
        end
        chk("tx_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("tx_tready_end", {31'd0, s_axis_tready}, 32'd1);

        // RX basic
        exp_q.push_back(8'h3C);
        fork
            rx_frame(8'h3C, 1'b1);
            begin
                repeat (1200) @(negedge clk);
                chk("rx_busy_mid", {31'd0, rx_busy}, 32'd1);
            end
        join
        repeat (20) @(negedge clk);
        chk("basic_out_cnt", out_cnt, 1);
        chk("basic_no_err", fe_cnt + ov_cnt, 0);
        chk("basic_busy_low", {31'd0, rx_busy}, 32'd0);

        // Overrun: 0x11 is overwritten by 0x22
        set_tready(1'b0);
        exp_q.push_back(8'h22);
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        chk("ovr_pulse_cnt", ov_cnt, 1);
        chk("ovr_valid_held", {31'd0, m_axis_tvalid}, 32'd1);
        chk("ovr_data", {24'd0, m_axis_tdata}, 32'h22);
        set_tready(1'b1);
        repeat (2) @(negedge clk);
        chk("ovr_valid_cleared", {31'd0, m_axis_tvalid}, 32'd0);
        chk("ovr_out_cnt", out_cnt, 2);

        // Frame error
        rx_frame(8'h5A, 1'b0);
        repeat (400) @(negedge clk);
        chk("fe_pulse_cnt", fe_cnt, 1);
        chk("fe_no_valid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("fe_busy_low", {31'd0, rx_busy}, 32'd0);

        // Glitch shorter than half a bit
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        chk("glitch_no_err", fe_cnt + ov_cnt, 2);
        chk("glitch_no_byte", out_cnt, 2);

        // Loopback, back-to-back frames
        loop_en = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'h55);
        repeat (2700) @(negedge clk);
        chk("loop_out_cnt", out_cnt, 5);
        chk("loop_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a looped-back frame
        tx_send(8'hC3);
        repeat (1000) @(negedge clk);
        chk("txd_low_before_reset", {31'd0, txd}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("txd_async_reset", {31'd0, txd}, 32'd1);
        chk("tready_in_reset", {31'd0, s_axis_tready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        chk("reset_no_byte", out_cnt, 5);
        chk("reset_no_err", fe_cnt + ov_cnt, 2);
        chk("reset_valid_low", {31'd0, m_axis_tvalid}, 32'd0);
        chk("reset_txd_idle", {31'd0, txd}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
